// File: rtl/mdu_pkg.sv
// Opcodes, state encoding and shared helpers for the multiply/divide controller.
// Define MDU_MADD_EN to enable the multiply-accumulate opcodes (MADD/MSUB).
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] WEN_LO   = 2'b01;
  localparam logic [1:0] WEN_HI   = 2'b10;
  localparam logic [1:0] WEN_BOTH = 2'b11;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS) + 1;

`ifdef MDU_MADD_EN
  // Clear these to build the unsigned MADDU/MSUBU variants on the same codes.
  localparam logic MADD_SIGNED = 1'b1;
  localparam logic MSUB_SIGNED = 1'b1;
`endif

  function automatic logic op_signed(input logic [2:0] op);
    logic s;
    case (op)
      OP_MULT, OP_DIV: s = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:         s = MADD_SIGNED;
      OP_MSUB:         s = MSUB_SIGNED;
`endif
      default:         s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider, one iteration per step.
// quotient/remainder present the values that the current step produces.
module div_iter
  import mdu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic [31:0]          dividend,
  input  logic [31:0]          divisor,
  output logic [31:0]          quotient,
  output logic [31:0]          remainder,
  output logic [DIV_CNT_W-1:0] count
);

  logic [31:0]          rem_q, rem_d;
  logic [31:0]          quo_q, quo_d;
  logic [31:0]          dvs_q, dvs_d;
  logic [DIV_CNT_W-1:0] count_q, count_d;
  logic [32:0]          shifted;
  logic                 fits;

  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    fits      = (shifted >= {1'b0, dvs_q});
    quotient  = {quo_q[30:0], fits};
    // When the trial fits, the difference is below the divisor and fits in 32 bits.
    remainder = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];

    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    count_d = count_q;
    if (start) begin
      rem_d   = '0;
      quo_d   = dividend;
      dvs_d   = divisor;
      count_d = '0;
    end else if (step) begin
      rem_d   = remainder;
      quo_d   = quotient;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer driving the HI/LO write port.
// Define MDU_MADD_EN to add MADD/MSUB with acc_hi/acc_lo inputs.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
`ifdef MDU_MADD_EN
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
`endif
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [1:0]  hilo_wen,
  output logic [31:0] hilo_hi,
  output logic [31:0] hilo_lo
);

  localparam int              CNT_W    = 3;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 2);

  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       wen_q, wen_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
`ifdef MDU_MADD_EN
  logic [63:0]      acc_q, acc_d;
  logic             acc_en_q, acc_en_d;
  logic             acc_sub_q, acc_sub_d;
`endif

  logic                 accept;
  logic                 req_signed;
  logic                 div_start, div_step;
  logic [31:0]          div_dvd, div_dvs, div_quot, div_rem;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic signed [63:0]   mul_a, mul_b, prod;
  logic [63:0]          mul_res;

  assign req_ready  = (state_q == ST_IDLE) & ~flush;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign hilo_wen   = done ? wen_q : 2'b00;
  assign hilo_hi    = hi_q;
  assign hilo_lo    = lo_q;

  assign accept     = req_valid & req_ready;
  assign req_signed = op_signed(req_op);
  assign div_dvd    = neg_if(req_a, req_signed & req_a[31]);
  assign div_dvs    = neg_if(req_b, req_signed & req_b[31]);

  div_iter u_div (
    .clk       (clk),
    .rst       (reset),
    .start     (div_start),
    .step      (div_step),
    .dividend  (div_dvd),
    .divisor   (div_dvs),
    .quotient  (div_quot),
    .remainder (div_rem),
    .count     (div_cnt)
  );

  // Sign-extending both operands to 64 bits makes one multiply serve both signednesses.
  always_comb begin
    mul_a = $signed({{32{sgn_q & a_q[31]}}, a_q});
    mul_b = $signed({{32{sgn_q & b_q[31]}}, b_q});
    prod  = mul_a * mul_b;
`ifdef MDU_MADD_EN
    if (acc_en_q) mul_res = acc_sub_q ? (acc_q - $unsigned(prod)) : (acc_q + $unsigned(prod));
    else          mul_res = $unsigned(prod);
`else
    mul_res = $unsigned(prod);
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    a_d        = a_q;
    b_d        = b_q;
    sgn_d      = sgn_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
`ifdef MDU_MADD_EN
    acc_d      = acc_q;
    acc_en_d   = acc_en_q;
    acc_sub_d  = acc_sub_q;
`endif
    div_start  = 1'b0;
    div_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MTHI: begin
              hi_d    = req_a;
              wen_d   = WEN_HI;
              state_d = ST_DONE;
            end
            OP_MTLO: begin
              lo_d    = req_a;
              wen_d   = WEN_LO;
              state_d = ST_DONE;
            end
            OP_MULT, OP_MULTU: begin
              a_d      = req_a;
              b_d      = req_b;
              sgn_d    = req_signed;
              cnt_d    = '0;
`ifdef MDU_MADD_EN
              acc_en_d = 1'b0;
`endif
              state_d  = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              quot_neg_d = req_signed & (req_a[31] ^ req_b[31]);
              rem_neg_d  = req_signed & req_a[31];
              div_start  = 1'b1;
              state_d    = ST_DIV;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: begin
              a_d       = req_a;
              b_d       = req_b;
              sgn_d     = req_signed;
              cnt_d     = '0;
              acc_d     = {acc_hi, acc_lo};
              acc_en_d  = 1'b1;
              acc_sub_d = (req_op == OP_MSUB);
              state_d   = ST_MUL;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          hi_d    = mul_res[63:32];
          lo_d    = mul_res[31:0];
          wen_d   = WEN_BOTH;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (div_cnt == DIV_CNT_W'(DIV_ITERS - 1)) begin
            lo_d    = neg_if(div_quot, quot_neg_q);
            hi_d    = neg_if(div_rem, rem_neg_q);
            wen_d   = WEN_BOTH;
            state_d = ST_DONE;
          end
        end
      end
      // The op committed before any flush, so DONE always completes its write.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wen_q   <= 2'b00;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q        <= a_d;
    b_q        <= b_d;
    sgn_q      <= sgn_d;
    quot_neg_q <= quot_neg_d;
    rem_neg_q  <= rem_neg_d;
`ifdef MDU_MADD_EN
    acc_q      <= acc_d;
    acc_en_q   <= acc_en_d;
    acc_sub_q  <= acc_sub_d;
`endif
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide controller that sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO and drives the write port of the HI/LO register pair.
- Accepts one operation at a time from the EX stage through a valid/ready handshake.
- Runs a fixed-latency multiply or a 32-iteration restoring divide.
- Issues a single write of HI, LO or both on completion.
- Exposes busy so the pipeline stalls MFHI/MFLO and further MDU ops while an operation is in flight.

Parameters:
MUL_CYCLES, 3, cycles from accept to HI/LO write for MULT/MULTU; legal range 2..8.

Ports:
clk        in   1   clock, all logic on rising edge
reset      in   1   synchronous, active-high reset
req_valid  in   1   operation request
req_ready  out  1   request accepted this cycle when req_valid & req_ready
req_op     in   3   operation code (see package)
req_a      in   32  rs operand / MT source
req_b      in   32  rt operand
flush      in   1   pipeline flush; aborts an in-flight MUL/DIV
busy       out  1   controller not idle; pipeline stalls HI/LO readers
done       out  1   one-cycle pulse coincident with the HI/LO write
hilo_wen   out  2   [1]=HI write enable, [0]=LO write enable
hilo_hi    out  32  HI write data
hilo_lo    out  32  LO write data

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset forces IDLE, counter=0, all outputs 0; reset wins over every other input, including mid-operation.
- req_ready = (state==IDLE) & !flush. busy = (state!=IDLE). done = (state==DONE). hilo_wen = 2'b00 outside DONE.
- Accept in IDLE:
  - MTHI/MTLO: latch req_a and go to DONE. The write occurs 1 cycle after accept with wen=10 (MTHI) or 01 (MTLO).
  - MULT/MULTU: latch the operands, go to MUL, counter=0. Compute the 64-bit product, signed or unsigned.
    - Advance to DONE when counter==MUL_CYCLES-2.
    - The write occurs MUL_CYCLES cycles after accept, wen=11, hi=product[63:32], lo=product[31:0].
  - DIV/DIVU: latch the operand magnitudes (two's-complement abs for DIV) and the signs, go to DIV.
    - One restoring iteration per cycle, 32 iterations.
    - Go to DONE after iteration 32. The write occurs 33 cycles after accept, wen=11.
- Divide result rules:
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a); lo=quotient, hi=remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
  - Divide by zero is not trapped and takes the same 33 cycles. DIVU gives lo=0xFFFFFFFF, hi=a. DIV gives lo = magnitude result 0xFFFFFFFF sign-fixed, hi=a.
- Undefined req_op is accepted and ignored: state stays IDLE and nothing is written.
- DONE lasts exactly one cycle, then IDLE. No request is accepted during DONE (ready=0). Back-to-back issue is therefore possible the cycle after DONE.
- Flush:
  - In MUL or DIV: next state IDLE, no write.
  - In IDLE: blocks acceptance.
  - In DONE: ignored; the write completes, because the op was committed before the flush.
- Write data is held stable whenever wen is asserted. Outside DONE it holds its last value and is don't-care.

Optional Feature:
MDU_MADD_EN
- With the macro: adds ops MADD/MADDU/MSUB/MSUBU and input ports acc_hi[31:0] and acc_lo[31:0] (current HI/LO). The result is {acc_hi,acc_lo} ± product, with the same MUL_CYCLES latency and wen=11. Accumulation is mod 2^64.
- Without the macro: those ports and opcodes do not exist, and the codes are treated as undefined.

Decomposition:
- Shared package mdu_pkg holds:
  - Opcode constants: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5, OP_MADD=6, OP_MSUB=7. Signedness of MADD/MSUB is selected by a package constant pair extended under the macro.
  - State encoding.
  - DIV_ITERS=32.
- Natural sub-module: div_iter, an unsigned radix-2 restoring divider with start/step/count, outputs quotient and remainder. Sign fix-up stays in mdu_ctrl.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> exactly 3 cycles after accept: wen=11, hi=0xFFFFFFFE, lo=0x00000001, done=1 for one cycle.
- DIV a=0xFFFFFFF9 (-7) b=2 -> cycle 33: lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy=1 for cycles 1..33, req_ready=0 throughout.
- DIVU a=0x00001234 b=0 -> cycle 33: lo=0xFFFFFFFF, hi=0x00001234.
- MTHI a=0x12345678 -> next cycle: wen=10, hi=0x12345678, lo untouched; MTLO issued the cycle after DONE is accepted.
- DIV then flush at cycle 10 -> no wen in any later cycle, busy=0 at cycle 11, a new MULT is accepted at cycle 11.
- reset asserted at cycle 5 of MULT (MUL_CYCLES=8) -> next cycle: state IDLE, busy=0, wen=00, done=0; no write ever occurs.
